// File: rtl/msg_packer.sv
// Collects a stream of ASCII bytes into a fixed-width message for the cypher.
// Holds the packed message with enable high until the consumer signals done.
module msg_packer #(
    parameter int          MSG_BYTES = 30,
    parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_byte,
    input  logic                               in_last,
    output logic [8*MSG_BYTES-1:0]             msg,
    output logic [$clog2(MSG_BYTES+1)-1:0]     msg_len,
    output logic                               enable,
    input  logic                               done
);

    localparam int CW = $clog2(MSG_BYTES + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [7:0]               buf_q [MSG_BYTES];
    logic [7:0]               buf_d [MSG_BYTES];
    logic [8*MSG_BYTES-1:0]   msg_q, msg_d;
    logic [CW-1:0]            msg_len_q, msg_len_d;
    logic                     accept;
    logic                     final_byte;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        count_d    = count_q;
        buf_d      = buf_q;
        msg_d      = msg_q;
        msg_len_d  = msg_len_q;

        in_ready   = (state_q == FILL) && (count_q < CW'(MSG_BYTES));
        enable     = (state_q == HOLD);
        accept     = in_valid && in_ready;
        final_byte = in_last || (count_q == CW'(MSG_BYTES - 1));

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < MSG_BYTES; k++) begin
                        if (k == int'(count_q)) buf_d[k] = in_byte;
                    end
                    count_d = count_q + CW'(1);
                    if (final_byte) begin
                        state_d   = HOLD;
                        msg_len_d = count_q + CW'(1);
                        // The byte arriving this edge is not yet in buf_q, so splice it in directly.
                        for (int k = 0; k < MSG_BYTES; k++) begin
                            if (k < int'(count_q))
                                msg_d[8*(MSG_BYTES-k)-1 -: 8] = buf_q[k];
                            else if (k == int'(count_q))
                                msg_d[8*(MSG_BYTES-k)-1 -: 8] = in_byte;
                            else
                                msg_d[8*(MSG_BYTES-k)-1 -: 8] = PAD_BYTE;
                        end
                    end
                end
            end
            HOLD: begin
                if (done) begin
                    state_d = FILL;
                    count_d = '0;
                    for (int k = 0; k < MSG_BYTES; k++) buf_d[k] = 8'h00;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            count_q   <= '0;
            msg_q     <= '0;
            msg_len_q <= '0;
            // NOTE: the byte buffer is reset too, since a reset must leave no residue of a partial message.
            for (int k = 0; k < MSG_BYTES; k++) buf_q[k] <= 8'h00;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            msg_q     <= msg_d;
            msg_len_q <= msg_len_d;
        end
    end

    assign msg     = msg_q;
    assign msg_len = msg_len_q;

endmodule

// File: tb/tb_msg_packer.sv
// Scoreboard bench for msg_packer: stimulus pushes expected messages, a monitor
// pops and compares on each rising enable and checks msg stability in between.
module tb_msg_packer;

    localparam int         MSG_BYTES = 30;
    localparam int         CW        = $clog2(MSG_BYTES + 1);
    localparam logic [7:0] PAD       = 8'h2E;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_byte;
    logic                   in_last;
    logic [8*MSG_BYTES-1:0] msg;
    logic [CW-1:0]          msg_len;
    logic                   enable;
    logic                   done;

    always #5 clk = ~clk;

    msg_packer #(.MSG_BYTES(MSG_BYTES), .PAD_BYTE(PAD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_byte  (in_byte),
        .in_last  (in_last),
        .msg      (msg),
        .msg_len  (msg_len),
        .enable   (enable),
        .done     (done)
    );

    typedef struct {
        logic [8*MSG_BYTES-1:0] m;
        logic [CW-1:0]          len;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t pop_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rst_prev = 1'b0;
    logic en_prev  = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [8*MSG_BYTES-1:0] m, input int len);
        exp_t e;
        e.m   = m;
        e.len = CW'(len);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        check("byte accepted", 256'(acc), 256'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        cur.m   = '0;
        cur.len = '0;
        forever begin
            @(negedge clk);
            if (!rst_prev) begin
                check("reset msg", 256'(msg), 256'(0));
                check("reset msg_len", 256'(msg_len), 256'(0));
                check("reset enable", 256'(enable), 256'(0));
                check("reset in_ready", 256'(in_ready), 256'(1));
                cur.m   = '0;
                cur.len = '0;
            end else if (enable && !en_prev) begin
                check("message expected", 256'(sb.size() > 0), 256'(1));
                if (sb.size() > 0) begin
                    pop_e = sb.pop_front();
                    check("msg", 256'(msg), 256'(pop_e.m));
                    check("msg_len", 256'(msg_len), 256'(pop_e.len));
                    cur = pop_e;
                end
            end else begin
                check("msg stable", 256'(msg), 256'(cur.m));
                check("msg_len stable", 256'(msg_len), 256'(cur.len));
            end
            rst_prev = rst_n;
            en_prev  = enable;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        string                  s;
        logic [8*MSG_BYTES-1:0] pat;

        s        = "Hello World! A secret message!";
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'h5A;
        in_last  = 1'b1;
        done     = 1'b1;

        // Reset held two cycles with a valid last byte presented.
        repeat (2) tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("post-reset enable", 256'(enable), 256'(0));
        check("post-reset in_ready", 256'(in_ready), 256'(1));
        check("post-reset msg_len", 256'(msg_len), 256'(0));

        // done while in FILL has no effect.
        repeat (2) begin
            tick();
            check("done ignored in FILL", 256'(enable), 256'(0));
        end
        done = 1'b0;

        // Short message "Hi".
        push({16'h4869, {28{PAD}}}, 2);
        send_byte(8'h48, 1'b0);
        send_byte(8'h69, 1'b1);
        check("short enable", 256'(enable), 256'(1));
        check("short in_ready", 256'(in_ready), 256'(0));

        // Backpressure: next byte presented during HOLD is not taken.
        in_valid = 1'b1;
        in_byte  = 8'h58;
        repeat (3) begin
            tick();
            check("hold in_ready", 256'(in_ready), 256'(0));
            check("hold enable", 256'(enable), 256'(1));
        end

        // done held three cycles releases once; bytes flow from the cycle after.
        done = 1'b1;
        tick();
        check("release enable", 256'(enable), 256'(0));
        check("release in_ready", 256'(in_ready), 256'(1));
        send_byte(8'h58, 1'b0);
        send_byte(8'h59, 1'b0);
        done = 1'b0;
        push({24'h58595A, {27{PAD}}}, 3);
        send_byte(8'h5A, 1'b1);
        check("xyz enable", 256'(enable), 256'(1));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("xyz release", 256'(enable), 256'(0));

        // Full 30-byte message, in_last on the final byte.
        push(240'h48656C6C6F20576F726C6421204120736563726574206D65737361676521, 30);
        for (int i = 0; i < MSG_BYTES; i++) send_byte(s[i], i == MSG_BYTES - 1);
        check("full enable", 256'(enable), 256'(1));
        check("full in_ready", 256'(in_ready), 256'(0));
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (3) begin
            check("single message", 256'(enable), 256'(0));
            tick();
        end

        // Full message without in_last: the 30th byte closes it.
        for (int i = 0; i < MSG_BYTES; i++) pat[8*(MSG_BYTES-i)-1 -: 8] = 8'(8'h30 + i);
        push(pat, 30);
        for (int i = 0; i < MSG_BYTES; i++) send_byte(8'(8'h30 + i), 1'b0);
        check("count-full enable", 256'(enable), 256'(1));
        check("count-full in_ready", 256'(in_ready), 256'(0));
        done = 1'b1;
        tick();
        done = 1'b0;

        // Reset mid-FILL discards the partial message.
        for (int i = 0; i < 10; i++) send_byte(8'(8'h61 + i), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid-fill reset enable", 256'(enable), 256'(0));
        check("mid-fill reset in_ready", 256'(in_ready), 256'(1));
        push({8'h41, {29{PAD}}}, 1);
        send_byte(8'h41, 1'b1);
        check("A enable", 256'(enable), 256'(1));

        // Reset mid-HOLD drops enable without done.
        tick();
        rst_n = 1'b0;
        tick();
        check("mid-hold reset enable", 256'(enable), 256'(0));
        rst_n = 1'b1;
        tick();
        check("after mid-hold reset enable", 256'(enable), 256'(0));
        tick();

        check("scoreboard drained", 256'(sb.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
